// File: rtl/wb_grf_pkg.sv
// Shared encodings for the write-back stage and general register file.
package wb_grf_pkg;

  typedef enum logic [1:0] {
    WB_SRC_AO  = 2'd0,
    WB_SRC_DR  = 2'd1,
    WB_SRC_PC8 = 2'd2,
    WB_SRC_MDU = 2'd3
  } wb_src_e;

  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_B  = 3'd1,
    LD_BU = 3'd2,
    LD_H  = 3'd3,
    LD_HU = 3'd4
  } ld_type_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_grf_load_ext.sv
// Load data extender: picks byte/half from the raw memory word by offset and extends it.
module load_ext
  import wb_grf_pkg::*;
(
  input  logic [31:0] dr,
  input  logic [1:0]  off,
  input  logic [2:0]  ltype,
  output logic [31:0] ext
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Halfword select uses only off[1]; misaligned halves are not trapped here.
  always_comb begin
    byte_v = dr[{off, 3'b000} +: 8];
    half_v = off[1] ? dr[31:16] : dr[15:0];
    ext    = dr;
    case (ltype)
      LD_B:    ext = {{24{byte_v[7]}}, byte_v};
      LD_BU:   ext = {24'd0, byte_v};
      LD_H:    ext = {{16{half_v[15]}}, half_v};
      LD_HU:   ext = {16'd0, half_v};
      default: ext = dr;
    endcase
  end

endmodule

// File: rtl/wb_grf.sv
// Write-back select, load extension and general register file with W-to-D bypass.
// Optional write trace printing is enabled by defining GRF_TRACE_EN.
module wb_grf
  import wb_grf_pkg::*;
#(
  parameter int          NREG     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  W_WR,
  input  logic [31:0] W_DR,
  input  logic [31:0] W_pc,
  input  logic [31:0] W_pc_add_8,
  input  logic [31:0] W_AO,
  input  logic [31:0] W_MDU_out,
  input  logic        RegWrite_W,
  input  logic [1:0]  MemtoReg_W,
  input  logic [2:0]  LoadType_W,
  input  logic [4:0]  D_rs_addr,
  input  logic [4:0]  D_rt_addr,
  output logic [31:0] D_rs_data,
  output logic [31:0] D_rt_data,
  output logic [31:0] W_WD
);

  logic [31:0] regs_q [NREG];
  logic [31:0] regs_d [NREG];
  logic [31:0] ld_data;
  logic        wr_en;

  load_ext u_load_ext (
    .dr    (W_DR),
    .off   (W_AO[1:0]),
    .ltype (LoadType_W),
    .ext   (ld_data)
  );

  always_comb begin
    W_WD = W_AO;
    case (MemtoReg_W)
      WB_SRC_AO:  W_WD = W_AO;
      WB_SRC_DR:  W_WD = ld_data;
      WB_SRC_PC8: W_WD = W_pc_add_8;
      WB_SRC_MDU: W_WD = W_MDU_out;
      default:    W_WD = W_AO;
    endcase
  end

  assign wr_en = RegWrite_W && (W_WR != REG_ZERO);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[W_WR] = W_WD;
  end

  // Reset wins over a coincident write; that write is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    D_rs_data = regs_q[D_rs_addr];
    if (D_rs_addr == REG_ZERO)                D_rs_data = '0;
    else if (wr_en && (W_WR == D_rs_addr))    D_rs_data = W_WD;
  end

  always_comb begin
    D_rt_data = regs_q[D_rt_addr];
    if (D_rt_addr == REG_ZERO)                D_rt_data = '0;
    else if (wr_en && (W_WR == D_rt_addr))    D_rt_data = W_WD;
  end

`ifdef GRF_TRACE_EN
  logic [31:0] trace_pc;
  assign trace_pc = reset ? RESET_PC : W_pc;

  // $0 writes are still traced, showing the value as presented.
  always @(posedge clk) begin
    if (!reset && RegWrite_W)
      $display("%0d@%h: $%2d <= %h", $time, trace_pc, W_WR, W_WD);
  end
`else
  logic unused_trace;
  assign unused_trace = ^{W_pc, RESET_PC};
`endif

endmodule

// File: tb/tb_wb_grf.sv
// Self-checking bench for wb_grf: directed cases plus randomized traffic against a reference model.
module tb_wb_grf;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  W_WR;
  logic [31:0] W_DR, W_pc, W_pc_add_8, W_AO, W_MDU_out;
  logic        RegWrite_W;
  logic [1:0]  MemtoReg_W;
  logic [2:0]  LoadType_W;
  logic [4:0]  D_rs_addr, D_rt_addr;
  logic [31:0] D_rs_data, D_rt_data, W_WD;

  int checks = 0;
  int errors = 0;
  logic [31:0] mdl [32];

  always #5 clk = ~clk;

  wb_grf dut (
    .clk        (clk),
    .reset      (reset),
    .W_WR       (W_WR),
    .W_DR       (W_DR),
    .W_pc       (W_pc),
    .W_pc_add_8 (W_pc_add_8),
    .W_AO       (W_AO),
    .W_MDU_out  (W_MDU_out),
    .RegWrite_W (RegWrite_W),
    .MemtoReg_W (MemtoReg_W),
    .LoadType_W (LoadType_W),
    .D_rs_addr  (D_rs_addr),
    .D_rt_addr  (D_rt_addr),
    .D_rs_data  (D_rs_data),
    .D_rt_data  (D_rt_data),
    .W_WD       (W_WD)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ext_model(input logic [31:0] dr, input logic [31:0] ao,
                                             input logic [2:0] lt);
    logic [31:0] v;
    int unsigned bidx, hidx;
    bidx = ao % 4;
    hidx = (ao / 2) % 2;
    case (lt)
      3'd1, 3'd2: begin
        v = (dr >> (8 * bidx)) & 32'hFF;
        if (lt == 3'd1 && v >= 32'd128) v = v - 32'd256;
      end
      3'd3, 3'd4: begin
        v = (dr >> (16 * hidx)) & 32'hFFFF;
        if (lt == 3'd3 && v >= 32'd32768) v = v - 32'd65536;
      end
      default: v = dr;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] wd_model();
    case (MemtoReg_W)
      2'd0: return W_AO;
      2'd1: return ext_model(W_DR, W_AO, LoadType_W);
      2'd2: return W_pc_add_8;
      default: return W_MDU_out;
    endcase
  endfunction

  function automatic logic [31:0] rd_model(input logic [4:0] a);
    if (a == 0) return 32'd0;
    if (RegWrite_W && W_WR == a) return wd_model();
    return mdl[a];
  endfunction

  // Advance one clock edge and mirror its architectural effect in the model.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    end else if (RegWrite_W && W_WR != 0) begin
      mdl[W_WR] = wd_model();
    end
    #1;
  endtask

  task automatic ld_case(input string tag, input logic [31:0] ao, input logic [2:0] lt,
                         input logic [31:0] exp);
    W_AO = ao; LoadType_W = lt; #1;
    chk(tag, W_WD, exp);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    reset = 1'b1; RegWrite_W = 1'b0; W_WR = 5'd0; W_DR = '0; W_pc = 32'h3000;
    W_pc_add_8 = '0; W_AO = '0; W_MDU_out = '0; MemtoReg_W = 2'd0; LoadType_W = 3'd0;
    D_rs_addr = 5'd5; D_rt_addr = 5'd31;
    tick(); tick();
    reset = 1'b0; #1;
    chk("rst_rs5", D_rs_data, 32'd0);
    chk("rst_rt31", D_rt_data, 32'd0);

    reset = 1'b1; RegWrite_W = 1'b1; W_WR = 5'd5; W_AO = 32'hAAAA_5555;
    tick();
    reset = 1'b0; RegWrite_W = 1'b0; #1;
    chk("rst_over_wr", D_rs_data, 32'd0);

    RegWrite_W = 1'b1; W_WR = 5'd8; MemtoReg_W = 2'd0; W_AO = 32'h1234_5678;
    tick();
    RegWrite_W = 1'b0; D_rs_addr = 5'd8; #1;
    chk("wr_rd8", D_rs_data, 32'h1234_5678);
    RegWrite_W = 1'b1; W_WR = 5'd0; D_rs_addr = 5'd0;
    tick();
    RegWrite_W = 1'b0; #1;
    chk("wr_r0", D_rs_data, 32'd0);

    D_rs_addr = 5'd9; D_rt_addr = 5'd9; W_WR = 5'd9; W_AO = 32'h0BAD_F00D; RegWrite_W = 1'b1;
    tick();
    W_AO = 32'hDEAD_BEEF; #1;
    chk("byp_rs", D_rs_data, 32'hDEAD_BEEF);
    chk("byp_rt", D_rt_data, 32'hDEAD_BEEF);
    RegWrite_W = 1'b0; #1;
    chk("nobyp_rs", D_rs_data, 32'h0BAD_F00D);
    chk("nobyp_rt", D_rt_data, 32'h0BAD_F00D);

    W_DR = 32'h80FF_7F01; MemtoReg_W = 2'd1;
    ld_case("lb_1",  32'd1, 3'd1, 32'h0000_007F);
    ld_case("lb_2",  32'd2, 3'd1, 32'hFFFF_FFFF);
    ld_case("lbu_3", 32'd3, 3'd2, 32'h0000_0080);
    ld_case("lh_2",  32'd2, 3'd3, 32'hFFFF_80FF);
    ld_case("lhu_0", 32'd0, 3'd4, 32'h0000_7F01);
    ld_case("lt6",   32'd1, 3'd6, 32'h80FF_7F01);
    ld_case("lh_3",  32'd3, 3'd3, 32'hFFFF_80FF);

    MemtoReg_W = 2'd2; W_pc_add_8 = 32'h3010; #1;
    chk("src_pc8", W_WD, 32'h3010);
    MemtoReg_W = 2'd3; W_MDU_out = 32'h7; W_WR = 5'd31; RegWrite_W = 1'b1; #1;
    chk("src_mdu", W_WD, 32'h7);
    tick();
    RegWrite_W = 1'b0; D_rs_addr = 5'd31; #1;
    chk("mdu_r31", D_rs_data, 32'h7);

    for (int n = 0; n < 400; n++) begin
      reset      = ($urandom_range(0, 39) == 0);
      RegWrite_W = ($urandom_range(0, 3) != 0);
      W_WR       = 5'($urandom_range(0, 31));
      W_DR       = $urandom;
      W_AO       = $urandom;
      W_pc       = 32'h3000 + 32'($urandom_range(0, 255)) * 4;
      W_pc_add_8 = W_pc + 32'd8;
      W_MDU_out  = $urandom;
      MemtoReg_W = 2'($urandom_range(0, 3));
      LoadType_W = 3'($urandom_range(0, 7));
      D_rs_addr  = ($urandom_range(0, 2) == 0) ? W_WR : 5'($urandom_range(0, 31));
      D_rt_addr  = ($urandom_range(0, 2) == 0) ? W_WR : 5'($urandom_range(0, 31));
      #1;
      chk("rnd_wd", W_WD, wd_model());
      chk("rnd_rs", D_rs_data, rd_model(D_rs_addr));
      chk("rnd_rt", D_rt_data, rd_model(D_rt_addr));
      tick();
    end

    reset = 1'b0; RegWrite_W = 1'b0;
    for (int i = 0; i < 32; i++) begin
      D_rs_addr = 5'(i); D_rt_addr = 5'(31 - i); #1;
      chk("final_rs", D_rs_data, rd_model(D_rs_addr));
      chk("final_rt", D_rt_data, rd_model(D_rt_addr));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
